// File: rtl/freq_enc_pkg.sv
// Shared types and helpers for the frequency pulse encoder.
// Period words travel as a fixed-width struct and are narrowed at the top.
package freq_enc_pkg;

  localparam int MAX_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [MAX_W-1:0] period;
    logic             oneshot;
  } word_t;

  // Effective high time: clipped so every period keeps a low cycle,
  // except P=1 where the output is meant to stay high.
  function automatic logic [MAX_W-1:0] w_eff(
    input logic [MAX_W-1:0] p,
    input logic [MAX_W-1:0] pw
  );
    logic [MAX_W-1:0] pm1;
    pm1 = p - MAX_W'(1);
    if (p <= MAX_W'(1)) return MAX_W'(1);
    return (pw < pm1) ? pw : pm1;
  endfunction

endpackage

// File: rtl/freq_enc_shadow_reg.sv
// One-deep valid/ready holding register with bypass.
// The head is the pending word if present, else the incoming word.
module freq_enc_shadow_reg
  import freq_enc_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  input  word_t in_word,
  input  logic  bypass,
  input  logic  take,
  output logic  ready,
  output logic  accept,
  output logic  pend_valid,
  output word_t head
);

  word_t word_q;
  logic  valid_q;

  assign ready      = !valid_q;
  assign accept     = in_valid & ready;
  assign pend_valid = valid_q;
  assign head       = valid_q ? word_q : in_word;

  // Capture accepted words the consumer cannot absorb this edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else if (take) begin
      valid_q <= 1'b0;
    end else if (accept && !bypass) begin
      valid_q <= 1'b1;
      word_q  <= in_word;
    end
  end

endmodule

// File: rtl/freq_pulse_encoder.sv
// Period word to pulse train encoder with programmable pulse width.
// New words take effect only at period boundaries.
module freq_pulse_encoder
  import freq_enc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PULSE_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic             oneshot_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             pulse_out,
  output logic             period_done,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             os_q, os_d;
  logic             pulse_q, done_q;
  logic             pulse_d, done_d;
  logic             last, run;
  logic             bypass, take, accept, pend_valid;
  word_t            in_word, head;

  assign in_word = '{period: MAX_W'(data_in), oneshot: oneshot_in};

  freq_enc_shadow_reg u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (data_valid),
    .in_word    (in_word),
    .bypass     (bypass),
    .take       (take),
    .ready      (data_ready),
    .accept     (accept),
    .pend_valid (pend_valid),
    .head       (head)
  );

  assign run  = (state_q == RUN) & enable;
  assign last = run & (count_q == period_q - ONE);

  // Next state: load on idle accept, count and resolve boundaries in RUN
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    os_d     = os_q;
    count_d  = count_q;
    bypass   = 1'b0;
    take     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          bypass = 1'b1;
          if (head.period != '0) begin
            state_d  = RUN;
            period_d = WIDTH'(head.period);
            os_d     = head.oneshot;
            count_d  = '0;
          end
        end
      end
      RUN: begin
        if (last) begin
          count_d = '0;
          if (pend_valid || accept) begin
            take     = pend_valid;
            bypass   = accept;
            period_d = WIDTH'(head.period);
            os_d     = head.oneshot;
            if (head.period == '0) state_d = IDLE;
          end else if (os_q) begin
            state_d = IDLE;
          end
        end else if (enable) begin
          count_d = count_q + ONE;
        end
      end
    endcase
  end

  // Output decode from the pre-edge count, registered below
  always_comb begin
    pulse_d = run & (MAX_W'(count_q) <
              w_eff(MAX_W'(period_q), MAX_W'(PULSE_W)));
    done_d  = last;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      period_q <= '0;
      os_q     <= 1'b0;
      count_q  <= '0;
      pulse_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      os_q     <= os_d;
      count_q  <= count_d;
      pulse_q  <= pulse_d;
      done_q   <= done_d;
    end
  end

  assign pulse_out   = pulse_q;
  assign period_done = done_q;
  assign busy        = (state_q == RUN);

endmodule

// File: doc/freq_pulse_encoder.md
Name: freq_pulse_encoder

Overview:
Parametrised successor to the team's single-compare frequency encoder. Converts a WIDTH-bit period word into a periodic pulse train on pulse_out, with a programmable pulse width and continuous or one-shot mode. New words are accepted through a valid/ready handshake into a one-deep shadow register and applied glitch-free at the next period boundary. Sits between the data-input front end and the output pad driver of the encoder/decoder chip.

Parameters:
WIDTH, 8, width of period word and period counter
PULSE_W, 1, nominal high time of each pulse in clk cycles (1..2**WIDTH-1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
enable  input  1  run/pause; low freezes counter and forces pulse_out low
data_in  input  WIDTH  period P in clk cycles; 0 = stop
oneshot_in  input  1  captured with data_in; 1 = emit one period then stop
data_valid  input  1  data_in/oneshot_in valid
data_ready  output  1  shadow register empty; word accepted when valid & ready at a rising edge
pulse_out  output  1  registered pulse train
period_done  output  1  one-cycle strobe at each period boundary
busy  output  1  high while state is RUN

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-low on rst_n.
- Reset (rst_n low at an edge): state IDLE, active_period=0, active_oneshot=0, counter=0, pending empty, pulse_out=0, period_done=0, busy=0, data_ready=1.
- Accept means data_valid & data_ready at a rising edge. data_ready = !pending_valid.
- States:
  - IDLE: pulse_out=0. On accept with P!=0, load active {P, oneshot} directly and set counter=0. The pending register is bypassed. Go to RUN. An accept with P=0 in IDLE is consumed and the block stays IDLE.
  - RUN: while enable=1, counter increments each edge. At counter==P-1 the edge is a boundary: counter<=0 and period_done pulses for the following cycle.
  - Boundary resolution, in priority order:
    - pending valid: load it and clear pending.
    - else accept on the same edge: load the new word directly.
    - else if active_oneshot: go to IDLE.
    - else repeat with the current word.
    - A loaded P=0 goes to IDLE.
  - While enable=0 in RUN: counter holds, no boundary occurs, pulse_out is 0 from the next edge. Accepts still fill pending.
- pulse_out is registered: pulse_out <= RUN & enable & (counter < W_eff), where W_eff = min(PULSE_W, P-1) for P>=2. For P=1, pulse_out stays high continuously.
- Latency: accept in IDLE at edge k gives pulse_out high after edge k+1. A following pulse starts every P cycles.
- period_done is registered and fires once per boundary, in both modes, including the final boundary in one-shot mode.
- busy = (state==RUN).
- Arithmetic: counter is WIDTH bits and cannot overflow since it never exceeds P-1. The comparison against W_eff is unsigned.
- Only one word may be pending. A second valid while pending is full is back-pressured (ready=0), never dropped.
- A reset asserted mid-period takes effect at the next edge regardless of enable or handshake.

Decomposition:
- Package freq_enc_pkg:
  - state enum (IDLE, RUN)
  - typedef for the period word {period, oneshot}
  - function computing W_eff
- One natural sub-module: freq_enc_shadow_reg, the one-deep valid/ready holding register with bypass. The counter/FSM stays in the top module.

Test Plan:
- Reset, then accept P=4, oneshot=0, PULSE_W=1, enable=1 -> pulse_out high 1 of every 4 cycles, first high after accept+1 edge; period_done every 4 cycles; busy=1.
- While running P=4, accept P=6 mid-period -> current 4-cycle period completes, next period is 6 cycles; data_ready low from accept until that boundary.
- Accept P=5, oneshot=1, PULSE_W=2 -> pulse_out high exactly 2 cycles, single period_done, then IDLE with busy=0.
- Running P=3, drop enable for 5 cycles -> pulse_out low, counter frozen, no period_done; on re-enable the period resumes from the frozen count.
- Edge cases: P=1 gives pulse_out constantly high. P=2 with PULSE_W=4 gives a 1-high/1-low pattern. Accept P=0 while running gives IDLE at the next boundary with pulse_out=0.
- Pulse rst_n low mid-period with pending full -> all outputs at reset values the next cycle and data_ready=1.
